// File: rtl/mkio_bus_switch.sv
// MKIO redundant-bus switch: locks onto the channel that carried the command, routes the
// response back onto that channel only, and supersedes on sustained activity elsewhere.
module mkio_bus_switch #(
  parameter int unsigned N_CH         = 2,
  parameter int unsigned IDLE_TIMEOUT = 128,
  parameter int unsigned SWITCH_FILT  = 16,
  parameter int unsigned GUARD_CYC    = 10,
  localparam int unsigned CW          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk32,
  input  logic            reset,
  input  logic [N_CH-1:0] di1,
  input  logic [N_CH-1:0] di0,
  input  logic [N_CH-1:0] ch_enable,
  output logic [N_CH-1:0] do1,
  output logic [N_CH-1:0] do0,
  output logic [N_CH-1:0] rx_strob,
  output logic [N_CH-1:0] tx_inhibit,
  output logic            rx_di1,
  output logic            rx_di0,
  input  logic            tx_do1,
  input  logic            tx_do0,
  input  logic            tx_busy,
  output logic            clk16,
  output logic [CW-1:0]   active_ch,
  output logic            locked,
  output logic            ch_switch,
  output logic            other_act
);

  localparam int unsigned IW = $clog2(IDLE_TIMEOUT + 1);
  localparam int unsigned FW = $clog2(SWITCH_FILT + 1);
  localparam int unsigned GW = $clog2(GUARD_CYC + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK  = 2'd1,
    ST_TX    = 2'd2,
    ST_GUARD = 2'd3
  } state_t;

  state_t                   state, state_n;
  logic [CW-1:0]            ach_n;
  logic [IW-1:0]            idle_cnt, idle_n;
  logic [GW-1:0]            guard_cnt, guard_n;
  logic [N_CH-1:0][FW-1:0]  filt, filt_n;
  logic                     sw_n, oact_n;

  logic [N_CH-1:0] meta_di1, meta_di0, s_di1, s_di0;
  logic [N_CH-1:0] act, tx_sel;
  logic [CW-1:0]   lowest_act, sup_ch;
  logic            sup_hit, tx_side;

  // Two-flop synchronisers on the line receiver outputs
  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      meta_di1 <= '0;
      meta_di0 <= '0;
      s_di1    <= '0;
      s_di0    <= '0;
    end else begin
      meta_di1 <= di1;
      meta_di0 <= di0;
      s_di1    <= meta_di1;
      s_di0    <= meta_di0;
    end
  end

  // A differential line showing unequal levels means bus activity
  always_comb begin
    act     = ch_enable & (s_di1 ^ s_di0);
    tx_side = (state == ST_TX) || (state == ST_GUARD);
    for (int i = 0; i < int'(N_CH); i++) begin
      tx_sel[i] = tx_side && (CW'(i) == active_ch);
    end
  end

  // Response goes only onto the locked channel, and never onto a disabled one
  assign do1 = {N_CH{tx_do1}} & tx_sel & ch_enable;
  assign do0 = {N_CH{tx_do0}} & tx_sel & ch_enable;

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      active_ch  <= '0;
      idle_cnt   <= '0;
      guard_cnt  <= '0;
      filt       <= '0;
      locked     <= 1'b0;
      ch_switch  <= 1'b0;
      other_act  <= 1'b0;
      clk16      <= 1'b0;
      rx_di1     <= 1'b0;
      rx_di0     <= 1'b0;
      rx_strob   <= '0;
      tx_inhibit <= '1;
    end else begin
      state      <= state_n;
      active_ch  <= ach_n;
      idle_cnt   <= idle_n;
      guard_cnt  <= guard_n;
      filt       <= filt_n;
      locked     <= (state_n != ST_IDLE);
      ch_switch  <= sw_n;
      other_act  <= oact_n;
      clk16      <= ~clk16;
      rx_di1     <= (state == ST_LOCK) ? s_di1[active_ch] : 1'b0;
      rx_di0     <= (state == ST_LOCK) ? s_di0[active_ch] : 1'b0;
      rx_strob   <= ch_enable & ~tx_sel;
      tx_inhibit <= ~tx_sel;
    end
  end

  always_comb begin
    state_n    = state;
    ach_n      = active_ch;
    idle_n     = idle_cnt;
    guard_n    = guard_cnt;
    filt_n     = '0;
    sw_n       = 1'b0;
    oact_n     = other_act;
    lowest_act = '0;
    sup_hit    = 1'b0;
    sup_ch     = '0;

    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (act[i]) lowest_act = CW'(i);
    end

    // Foreign activity while we are answering is only reported, never acted on
    if (tx_side) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        if (act[i] && (CW'(i) != active_ch)) oact_n = 1'b1;
      end
    end

    case (state)
      ST_IDLE: begin
        idle_n  = '0;
        guard_n = '0;
        if (|act) begin
          state_n = ST_LOCK;
          ach_n   = lowest_act;
        end
      end

      ST_LOCK: begin
        if (act[active_ch]) idle_n = '0;
        else if (idle_cnt != IW'(IDLE_TIMEOUT)) idle_n = idle_cnt + IW'(1);

        // Descending scan leaves the lowest qualifying channel in sup_ch
        for (int j = int'(N_CH) - 1; j >= 0; j--) begin
          if (act[j] && (CW'(j) != active_ch)) begin
            filt_n[j] = (filt[j] == FW'(SWITCH_FILT)) ? filt[j] : filt[j] + FW'(1);
          end
          if (filt_n[j] == FW'(SWITCH_FILT)) begin
            sup_hit = 1'b1;
            sup_ch  = CW'(j);
          end
        end

        if (!ch_enable[active_ch]) begin
          state_n = ST_IDLE;
          idle_n  = '0;
          filt_n  = '0;
        end else if (tx_busy) begin
          state_n = ST_TX;
          guard_n = '0;
          filt_n  = '0;
        end else if (sup_hit) begin
          ach_n  = sup_ch;
          sw_n   = 1'b1;
          idle_n = '0;
          filt_n = '0;
        end else if (idle_n == IW'(IDLE_TIMEOUT)) begin
          state_n = ST_IDLE;
          idle_n  = '0;
          filt_n  = '0;
        end
      end

      ST_TX: begin
        if (!tx_busy) begin
          state_n = ST_GUARD;
          guard_n = '0;
        end
      end

      ST_GUARD: begin
        if (tx_busy) begin
          state_n = ST_TX;
        end else begin
          if (guard_cnt != GW'(GUARD_CYC)) guard_n = guard_cnt + GW'(1);
          if (guard_n == GW'(GUARD_CYC)) begin
            state_n = ST_LOCK;
            idle_n  = '0;
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mkio_bus_switch.sv
// Bench for mkio_bus_switch: directed table, corner-case sequences and random traffic
// compared every cycle against a timestamp-based reference model.
module tb_mkio_bus_switch;

  localparam int N_CH = 2;
  localparam int IT   = 128;
  localparam int SF   = 16;
  localparam int GC   = 10;

  logic clk32 = 1'b0;
  logic reset = 1'b0;
  logic [1:0] di1 = '0, di0 = '0, ch_enable = 2'b11;
  logic tx_do1 = 1'b0, tx_do0 = 1'b0, tx_busy = 1'b0;
  logic [1:0] do1, do0, rx_strob, tx_inhibit;
  logic rx_di1, rx_di0, clk16, locked, ch_switch, other_act;
  logic [0:0] active_ch;

  int checks = 0;
  int errors = 0;

  always #5 clk32 = ~clk32;

  mkio_bus_switch #(.N_CH(N_CH), .IDLE_TIMEOUT(IT), .SWITCH_FILT(SF), .GUARD_CYC(GC)) dut (
    .clk32(clk32), .reset(reset), .di1(di1), .di0(di0), .ch_enable(ch_enable),
    .do1(do1), .do0(do0), .rx_strob(rx_strob), .tx_inhibit(tx_inhibit),
    .rx_di1(rx_di1), .rx_di0(rx_di0), .tx_do1(tx_do1), .tx_do0(tx_do0),
    .tx_busy(tx_busy), .clk16(clk16), .active_ch(active_ch), .locked(locked),
    .ch_switch(ch_switch), .other_act(other_act)
  );

  // Reference model: bus mode plus timestamps of the last relevant events
  localparam int M_IDLE = 0, M_LOCK = 1, M_TX = 2, M_GUARD = 3;
  int         m_mode, m_ach;
  longint     k, m_last, m_gstart;
  longint     m_run [N_CH];
  logic       m_sw, m_oact, m_locked, m_rx1, m_rx0, m_clk16;
  logic [1:0] m_strob, m_inh, a, sd1, sd0;
  logic [1:0] h1[$], h0[$];
  int         sup;
  logic       near;

  always @(posedge clk32 or posedge reset) begin
    if (reset) begin
      m_mode = M_IDLE; m_ach = 0; k = 0; m_last = 0; m_gstart = 0;
      for (int i = 0; i < N_CH; i++) m_run[i] = -1;
      m_sw = 0; m_oact = 0; m_locked = 0; m_rx1 = 0; m_rx0 = 0; m_clk16 = 0;
      m_strob = 2'b00; m_inh = 2'b11;
      h1 = {}; h0 = {};
      h1.push_back(2'b00); h1.push_back(2'b00);
      h0.push_back(2'b00); h0.push_back(2'b00);
    end else begin
      sd1 = h1[0]; sd0 = h0[0];
      a = ch_enable & (sd1 ^ sd0);
      near = (m_mode == M_TX) || (m_mode == M_GUARD);
      for (int i = 0; i < N_CH; i++) begin
        m_inh[i]   = !(near && i == m_ach);
        m_strob[i] = ch_enable[i] && !(near && i == m_ach);
      end
      m_rx1 = (m_mode == M_LOCK) ? sd1[m_ach] : 1'b0;
      m_rx0 = (m_mode == M_LOCK) ? sd0[m_ach] : 1'b0;
      m_sw = 0;
      if (near) for (int j = 0; j < N_CH; j++) if (j != m_ach && a[j]) m_oact = 1;
      case (m_mode)
        M_IDLE: if (a != 0) begin
          m_ach = a[0] ? 0 : 1;
          m_mode = M_LOCK; m_last = k;
          for (int i = 0; i < N_CH; i++) m_run[i] = -1;
        end
        M_LOCK: begin
          sup = -1;
          for (int j = N_CH - 1; j >= 0; j--) begin
            if (j != m_ach && a[j]) begin
              if (m_run[j] < 0) m_run[j] = k;
            end else m_run[j] = -1;
            if (m_run[j] >= 0 && k - m_run[j] + 1 >= SF) sup = j;
          end
          if (a[m_ach]) m_last = k;
          if (!ch_enable[m_ach] || tx_busy) begin
            m_mode = tx_busy && ch_enable[m_ach] ? M_TX : M_IDLE;
            for (int i = 0; i < N_CH; i++) m_run[i] = -1;
          end else if (sup >= 0) begin
            m_ach = sup; m_sw = 1; m_last = k;
            for (int i = 0; i < N_CH; i++) m_run[i] = -1;
          end else if (k - m_last >= IT) begin
            m_mode = M_IDLE;
            for (int i = 0; i < N_CH; i++) m_run[i] = -1;
          end
        end
        M_TX: if (!tx_busy) begin m_mode = M_GUARD; m_gstart = k; end
        default: begin
          if (tx_busy) m_mode = M_TX;
          else if (k - m_gstart >= GC) begin m_mode = M_LOCK; m_last = k; end
        end
      endcase
      m_locked = (m_mode != M_IDLE);
      m_clk16 = ~m_clk16;
      void'(h1.pop_front()); void'(h0.pop_front());
      h1.push_back(di1); h0.push_back(di0);
      k++;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [1:0] e1, e0;
    e1 = 2'b00; e0 = 2'b00;
    if ((m_mode == M_TX || m_mode == M_GUARD) && ch_enable[m_ach]) begin
      e1[m_ach] = tx_do1; e0[m_ach] = tx_do0;
    end
    chk("m_locked", 32'(locked), 32'(m_locked));
    chk("m_active_ch", 32'(active_ch), 32'(m_ach));
    chk("m_ch_switch", 32'(ch_switch), 32'(m_sw));
    chk("m_other_act", 32'(other_act), 32'(m_oact));
    chk("m_rx_di1", 32'(rx_di1), 32'(m_rx1));
    chk("m_rx_di0", 32'(rx_di0), 32'(m_rx0));
    chk("m_rx_strob", 32'(rx_strob), 32'(m_strob));
    chk("m_tx_inhibit", 32'(tx_inhibit), 32'(m_inh));
    chk("m_do1", 32'(do1), 32'(e1));
    chk("m_do0", 32'(do0), 32'(e0));
    chk("m_clk16", 32'(clk16), 32'(m_clk16));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk32);
      check_model();
    end
  endtask

  typedef struct {
    logic [1:0] d1, d0, en;
    logic       busy, t1, t0;
    int         n;
    logic       e_lock, e_ach;
    logic [1:0] e_strob, e_inh, e_do1;
    logic       e_rx1, e_oact;
  } vec_t;

  vec_t tbl[13];
  logic [1:0] on_f;
  int busy_left, pulses;
  logic b;

  initial begin
    tbl[0]  = '{2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0,   3, 1'b0, 1'b0, 2'b11, 2'b11, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{2'b10, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0,   2, 1'b0, 1'b0, 2'b11, 2'b11, 2'b00, 1'b0, 1'b0};
    tbl[2]  = '{2'b10, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0,   1, 1'b1, 1'b1, 2'b11, 2'b11, 2'b00, 1'b0, 1'b0};
    tbl[3]  = '{2'b10, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0,   1, 1'b1, 1'b1, 2'b11, 2'b11, 2'b00, 1'b1, 1'b0};
    tbl[4]  = '{2'b11, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0,  10, 1'b1, 1'b1, 2'b11, 2'b11, 2'b00, 1'b1, 1'b0};
    tbl[5]  = '{2'b10, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0,   5, 1'b1, 1'b1, 2'b11, 2'b11, 2'b00, 1'b1, 1'b0};
    tbl[6]  = '{2'b10, 2'b00, 2'b11, 1'b1, 1'b1, 1'b0,   3, 1'b1, 1'b1, 2'b01, 2'b01, 2'b10, 1'b0, 1'b0};
    tbl[7]  = '{2'b11, 2'b00, 2'b11, 1'b1, 1'b1, 1'b0,   5, 1'b1, 1'b1, 2'b01, 2'b01, 2'b10, 1'b0, 1'b1};
    tbl[8]  = '{2'b10, 2'b00, 2'b11, 1'b0, 1'b1, 1'b0,  10, 1'b1, 1'b1, 2'b01, 2'b01, 2'b10, 1'b0, 1'b1};
    tbl[9]  = '{2'b10, 2'b00, 2'b11, 1'b0, 1'b1, 1'b0,   1, 1'b1, 1'b1, 2'b01, 2'b01, 2'b00, 1'b0, 1'b1};
    tbl[10] = '{2'b10, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0,   1, 1'b1, 1'b1, 2'b11, 2'b11, 2'b00, 1'b1, 1'b1};
    tbl[11] = '{2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 129, 1'b1, 1'b1, 2'b11, 2'b11, 2'b00, 1'b0, 1'b1};
    tbl[12] = '{2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0,   1, 1'b0, 1'b1, 2'b11, 2'b11, 2'b00, 1'b0, 1'b1};

    // Power-up reset
    #1 reset = 1'b1;
    #1;
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_tx_inhibit", 32'(tx_inhibit), 32'h3);
    chk("rst_rx_strob", 32'(rx_strob), 32'h0);
    chk("rst_clk16", 32'(clk16), 32'd0);
    step(2);
    reset = 1'b0;
    step(1);
    chk("first_rx_strob", 32'(rx_strob), 32'h3);

    // Directed table: lock on ch1, transmit, guard, timeout
    for (int r = 0; r < 13; r++) begin
      di1 = tbl[r].d1; di0 = tbl[r].d0; ch_enable = tbl[r].en;
      tx_busy = tbl[r].busy; tx_do1 = tbl[r].t1; tx_do0 = tbl[r].t0;
      step(tbl[r].n);
      chk($sformatf("tbl%0d_locked", r), 32'(locked), 32'(tbl[r].e_lock));
      chk($sformatf("tbl%0d_active_ch", r), 32'(active_ch), 32'(tbl[r].e_ach));
      chk($sformatf("tbl%0d_rx_strob", r), 32'(rx_strob), 32'(tbl[r].e_strob));
      chk($sformatf("tbl%0d_tx_inhibit", r), 32'(tx_inhibit), 32'(tbl[r].e_inh));
      chk($sformatf("tbl%0d_do1", r), 32'(do1), 32'(tbl[r].e_do1));
      chk($sformatf("tbl%0d_rx_di1", r), 32'(rx_di1), 32'(tbl[r].e_rx1));
      chk($sformatf("tbl%0d_other_act", r), 32'(other_act), 32'(tbl[r].e_oact));
    end

    // Simultaneous activity picks ch0; sustained ch1 supersedes with one pulse
    di1 = 2'b11; di0 = 2'b00;
    step(3);
    chk("sim_locked", 32'(locked), 32'd1);
    chk("sim_active_ch", 32'(active_ch), 32'd0);
    pulses = 0;
    repeat (15) begin step(1); pulses += int'(ch_switch); end
    chk("sup_early_pulses", 32'(pulses), 32'd0);
    chk("sup_early_ch", 32'(active_ch), 32'd0);
    step(1);
    chk("sup_ch", 32'(active_ch), 32'd1);
    chk("sup_pulse", 32'(ch_switch), 32'd1);
    di1 = 2'b10;
    step(1);
    chk("sup_pulse_end", 32'(ch_switch), 32'd0);
    pulses = 0;
    repeat (20) begin step(1); pulses += int'(ch_switch); end
    chk("sup_late_pulses", 32'(pulses), 32'd0);
    chk("sup_hold_ch", 32'(active_ch), 32'd1);

    // One-cycle activity at idle count 127 restarts the timeout
    di1 = 2'b00;
    step(126);
    di1 = 2'b10;
    step(1);
    di1 = 2'b00;
    step(3);
    chk("restart_locked_a", 32'(locked), 32'd1);
    step(126);
    chk("restart_locked_b", 32'(locked), 32'd1);
    step(1);
    chk("restart_unlock", 32'(locked), 32'd0);

    // Reset in the middle of a transmission
    di1 = 2'b10;
    step(3);
    tx_busy = 1'b1; tx_do1 = 1'b1; tx_do0 = 1'b0;
    step(4);
    chk("tx_do1", 32'(do1), 32'h2);
    di1 = 2'b11;
    step(3);
    chk("tx_other_act", 32'(other_act), 32'd1);
    chk("tx_no_switch", 32'(active_ch), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_locked", 32'(locked), 32'd0);
    chk("arst_active_ch", 32'(active_ch), 32'd0);
    chk("arst_other_act", 32'(other_act), 32'd0);
    chk("arst_tx_inhibit", 32'(tx_inhibit), 32'h3);
    chk("arst_rx_strob", 32'(rx_strob), 32'h0);
    chk("arst_do1", 32'(do1), 32'h0);
    chk("arst_rx_di1", 32'(rx_di1), 32'd0);
    ch_enable = 2'b10; tx_busy = 1'b0; di1 = 2'b01; di0 = 2'b00;
    step(2);
    reset = 1'b0;
    step(1);
    chk("post_rst_rx_strob", 32'(rx_strob), 32'h2);
    step(20);
    chk("masked_ch0_no_lock", 32'(locked), 32'd0);

    // Random traffic against the model
    on_f = 2'b00; busy_left = 0; ch_enable = 2'b11;
    for (int c = 0; c < 6000; c++) begin
      for (int i = 0; i < N_CH; i++) begin
        if (on_f[i] ? ($urandom_range(29) == 0) : ($urandom_range(149) == 0)) on_f[i] = ~on_f[i];
        b = 1'($urandom);
        di1[i] = b;
        di0[i] = on_f[i] ? ~b : b;
      end
      if (busy_left > 0) begin
        busy_left--;
        tx_busy = 1'b1;
      end else begin
        tx_busy = 1'b0;
        if ($urandom_range(59) == 0) busy_left = $urandom_range(120, 5);
      end
      if ($urandom_range(299) == 0)
        ch_enable = ($urandom_range(2) == 0) ? 2'($urandom) : 2'b11;
      tx_do1 = 1'($urandom);
      tx_do0 = ~tx_do1;
      step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
